sort_oet_seq: RTL and testbench

//  Iterative odd-even transposition sorter: accepts a NUM_VALS x SIZE vector via valid/ready, sorts it in place over
//  NUM_VALS clock cycles with NUM_VALS/2 compare-exchange units, returns it via valid/ready. Sequential, handshaked

---
 rtl/sort_oet_seq.sv | 175 +++++++++++++++++
 tb/tb_sort_oet_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_oet_seq.sv
// sort_oet_seq
//   Iterative odd-even transposition sorter. A NUM_VALS x SIZE vector is accepted
//   over a valid/ready handshake and sorted in place, one phase per clock, by
//   NUM_VALS/2 compare-exchange units. The result is returned over a second
//   valid/ready handshake. Ascending or descending order is chosen per vector
//   and latched when the vector is accepted.
//
//   Optional build macro: SORT_INDEX_EN
//     When defined, every element carries an IW-bit tag holding its original
//     input position. Tags swap together with the data and appear on o_index.
//
// Ports
//   i_clk, i_rst_n  clock and asynchronous active-low reset
//   i_valid/o_ready input handshake (o_ready is high only while idle)
//   i_descending    order select, sampled on accept
//   i_data          input vector, element k at [k*SIZE +: SIZE]
//   o_valid/i_ready output handshake (o_valid holds with stable data until taken)
//   o_data          sorted vector, same packing as i_data
//   o_index         (SORT_INDEX_EN) original position of each o_data element
//   o_busy          high whenever the FSM is not idle
module sort_oet_seq #(
    parameter int NUM_VALS = 5,
    parameter int SIZE     = 16,
    localparam int IW      = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic                     i_descending,
    input  logic [NUM_VALS*SIZE-1:0] i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_VALS*SIZE-1:0] o_data,
`ifdef SORT_INDEX_EN
    output logic [NUM_VALS*IW-1:0]   o_index,
`endif
    output logic                     o_busy
);

    localparam int CW = $clog2(NUM_VALS) + 1;

    generate
        if (NUM_VALS < 2) begin : g_bad_param
            $error("sort_oet_seq: NUM_VALS must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     mode_q, mode_d;
    logic [SIZE-1:0]          work_q [NUM_VALS];
    logic [SIZE-1:0]          work_d [NUM_VALS];
    logic [SIZE-1:0]          net_w  [NUM_VALS];
    logic [NUM_VALS*SIZE-1:0] out_q, out_d;

`ifdef SORT_INDEX_EN
    logic [IW-1:0]            tag_q [NUM_VALS];
    logic [IW-1:0]            tag_d [NUM_VALS];
    logic [IW-1:0]            net_t [NUM_VALS];
    logic [NUM_VALS*IW-1:0]   oidx_q, oidx_d;
`endif

    // One transposition phase. Even phases pair (0,1),(2,3)..; odd phases pair
    // (1,2),(3,4)... Pairs within a phase never overlap, so every unit reads the
    // registered values. The compare is strict, so equal elements never swap and
    // the sort is stable.
    always_comb begin
        net_w = work_q;
`ifdef SORT_INDEX_EN
        net_t = tag_q;
`endif
        for (int i = 0; i < NUM_VALS - 1; i++) begin
            if (i[0] == cnt_q[0]) begin
                if (mode_q ? (work_q[i] < work_q[i+1]) : (work_q[i] > work_q[i+1])) begin
                    net_w[i]   = work_q[i+1];
                    net_w[i+1] = work_q[i];
`ifdef SORT_INDEX_EN
                    net_t[i]   = tag_q[i+1];
                    net_t[i+1] = tag_q[i];
`endif
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        out_d   = out_q;
`ifdef SORT_INDEX_EN
        tag_d   = tag_q;
        oidx_d  = oidx_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    for (int k = 0; k < NUM_VALS; k++) begin
                        work_d[k] = i_data[k*SIZE +: SIZE];
`ifdef SORT_INDEX_EN
                        tag_d[k]  = IW'(k);
`endif
                    end
                    mode_d  = i_descending;
                    cnt_d   = '0;
                    state_d = SORT;
                end
            end
            SORT: begin
                work_d = net_w;
`ifdef SORT_INDEX_EN
                tag_d  = net_t;
`endif
                if (cnt_q == CW'(NUM_VALS - 1)) begin
                    // Result register is only written here, so o_data keeps the
                    // previous result while idle and during the next sort.
                    for (int k = 0; k < NUM_VALS; k++) begin
                        out_d[k*SIZE +: SIZE] = net_w[k];
`ifdef SORT_INDEX_EN
                        oidx_d[k*IW +: IW]    = net_t[k];
`endif
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            out_q   <= '0;
            for (int k = 0; k < NUM_VALS; k++) work_q[k] <= '0;
`ifdef SORT_INDEX_EN
            oidx_q  <= '0;
            for (int k = 0; k < NUM_VALS; k++) tag_q[k] <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            work_q  <= work_d;
`ifdef SORT_INDEX_EN
            oidx_q  <= oidx_d;
            tag_q   <= tag_d;
`endif
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign o_busy  = (state_q != IDLE);
    assign o_data  = out_q;
`ifdef SORT_INDEX_EN
    assign o_index = oidx_q;
`endif

endmodule

// File: tb/tb_sort_oet_seq.sv
module tb_sort_oet_seq;
    localparam int N  = 5;
    localparam int W  = 16;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           i_valid, i_descending, i_ready;
    logic [N*W-1:0] i_data;
    logic           o_ready, o_valid, o_busy;
    logic [N*W-1:0] o_data;
    logic [N*IW-1:0] o_index;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sort_oet_seq #(.NUM_VALS(N), .SIZE(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(i_valid), .o_ready(o_ready), .i_descending(i_descending),
        .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
`ifdef SORT_INDEX_EN
        .o_index(o_index),
`endif
        .o_busy(o_busy)
    );

`ifndef SORT_INDEX_EN
    assign o_index = '0;
`endif

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] a0, a1, a2, a3, a4);
        return {a4, a3, a2, a1, a0};
    endfunction

    function automatic logic [N*IW-1:0] pki(input int a0, a1, a2, a3, a4);
        return {IW'(a4), IW'(a3), IW'(a2), IW'(a1), IW'(a0)};
    endfunction

    // Drives one vector (entered at a negedge while idle) and waits for o_valid.
    // lat = number of negedges after the accepting edge until o_valid was seen.
    task automatic send_and_wait(input logic [N*W-1:0] din, input logic desc, input logic rdy,
                                 output int lat, output logic [N*W-1:0] dout,
                                 output logic [N*IW-1:0] iout);
        i_data = din; i_descending = desc; i_valid = 1'b1; i_ready = rdy;
        @(negedge clk);
        i_valid = 1'b0;
        i_descending = ~desc;
        lat = 1;
        while (!o_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        dout = o_data;
        iout = o_index;
    endtask

    task automatic test_reset;
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: valid=%b ready=%b busy=%b want 0 1 0", o_valid, o_ready, o_busy);
        end
        total++;
        if (o_data !== '0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", o_data);
        end
`ifdef SORT_INDEX_EN
        total++;
        if (o_index !== '0) begin
            bad++;
            $display("FAIL reset_index: got %h want 0", o_index);
        end
`endif
    endtask

    task automatic test_descending;
        int lat; logic [N*W-1:0] d; logic [N*IW-1:0] ix;
        send_and_wait(pk(3, 9, 1, 7, 5), 1'b1, 1'b1, lat, d, ix);
        total++;
        if (lat !== 6) begin
            bad++;
            $display("FAIL desc_latency: got %0d want 6", lat);
        end
        total++;
        if (d !== pk(9, 7, 5, 3, 1)) begin
            bad++;
            $display("FAIL desc_data: got %h want %h", d, pk(9, 7, 5, 3, 1));
        end
`ifdef SORT_INDEX_EN
        total++;
        if (ix !== pki(1, 3, 4, 0, 2)) begin
            bad++;
            $display("FAIL desc_index: got %h want %h", ix, pki(1, 3, 4, 0, 2));
        end
`endif
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== pk(9, 7, 5, 3, 1)) begin
            bad++;
            $display("FAIL desc_idle_hold: valid=%b ready=%b data=%h", o_valid, o_ready, o_data);
        end
    endtask

    task automatic test_reset_midsort;
        i_data = pk(1, 2, 3, 4, 5); i_descending = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL midsort_busy: got %b want 1", o_busy);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== '0) begin
            bad++;
            $display("FAIL midsort_reset: valid=%b busy=%b data=%h want 0 0 0", o_valid, o_busy, o_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1 || o_busy !== 1'b0 || o_valid !== 1'b0) begin
            bad++;
            $display("FAIL midsort_release: ready=%b busy=%b valid=%b want 1 0 0", o_ready, o_busy, o_valid);
        end
    endtask

    task automatic test_ascending_stable;
        int lat; logic [N*W-1:0] d; logic [N*IW-1:0] ix;
        send_and_wait(pk(4, 2, 4, 2, 0), 1'b0, 1'b1, lat, d, ix);
        total++;
        if (lat !== 6 || d !== pk(0, 2, 2, 4, 4)) begin
            bad++;
            $display("FAIL asc_stable: lat=%0d got %h want %h", lat, d, pk(0, 2, 2, 4, 4));
        end
`ifdef SORT_INDEX_EN
        total++;
        if (ix !== pki(4, 1, 3, 0, 2)) begin
            bad++;
            $display("FAIL asc_stable_index: got %h want %h", ix, pki(4, 1, 3, 0, 2));
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_extremes;
        int lat; logic [N*W-1:0] d; logic [N*IW-1:0] ix;
        send_and_wait(pk(16'hFFFF, 0, 16'hFFFF, 0, 16'h8000), 1'b1, 1'b1, lat, d, ix);
        total++;
        if (d !== pk(16'hFFFF, 16'hFFFF, 16'h8000, 0, 0)) begin
            bad++;
            $display("FAIL extremes_desc: got %h want %h", d, pk(16'hFFFF, 16'hFFFF, 16'h8000, 0, 0));
        end
`ifdef SORT_INDEX_EN
        total++;
        if (ix !== pki(0, 2, 4, 1, 3)) begin
            bad++;
            $display("FAIL extremes_index: got %h want %h", ix, pki(0, 2, 4, 1, 3));
        end
`endif
        @(negedge clk);
        send_and_wait(pk(1, 2, 3, 4, 5), 1'b0, 1'b1, lat, d, ix);
        total++;
        if (d !== pk(1, 2, 3, 4, 5)) begin
            bad++;
            $display("FAIL presorted: got %h want %h", d, pk(1, 2, 3, 4, 5));
        end
        @(negedge clk);
        send_and_wait(pk(5, 4, 3, 2, 1), 1'b0, 1'b1, lat, d, ix);
        total++;
        if (d !== pk(1, 2, 3, 4, 5)) begin
            bad++;
            $display("FAIL reversed: got %h want %h", d, pk(1, 2, 3, 4, 5));
        end
`ifdef SORT_INDEX_EN
        total++;
        if (ix !== pki(4, 3, 2, 1, 0)) begin
            bad++;
            $display("FAIL reversed_index: got %h want %h", ix, pki(4, 3, 2, 1, 0));
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int lat; logic [N*W-1:0] d; logic [N*IW-1:0] ix;
        int errs = 0;
        send_and_wait(pk(10, 30, 20, 50, 40), 1'b0, 1'b0, lat, d, ix);
        for (int c = 0; c < 20; c++) begin
            i_valid = c[0];
            i_data  = pk(7, 7, 7, 7, 7);
            @(negedge clk);
            if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== pk(10, 20, 30, 40, 50)) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL backpressure_hold: %0d bad cycles, last valid=%b ready=%b data=%h", errs, o_valid, o_ready, o_data);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        total++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== pk(10, 20, 30, 40, 50)) begin
            bad++;
            $display("FAIL backpressure_release: valid=%b ready=%b data=%h want 0 1 held", o_valid, o_ready, o_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a [N];
        int           ix [N];
        logic [W-1:0] tv; int ti;
        logic         desc;
        logic [N*W-1:0] exp_d;
        logic [N*IW-1:0] exp_i;
        int c;
        i_ready = 1'b1;
        i_valid = 1'b1;
        for (int v = 0; v < 100; v++) begin
            desc = 1'($urandom_range(0, 1));
            for (int k = 0; k < N; k++) begin
                a[k]  = v[0] ? W'($urandom_range(0, 3)) : W'($urandom);
                ix[k] = k;
                i_data[k*W +: W] = a[k];
            end
            i_descending = desc;
            // stable insertion sort reference
            for (int i = 1; i < N; i++)
                for (int j = i; j > 0; j--)
                    if (desc ? (a[j-1] < a[j]) : (a[j-1] > a[j])) begin
                        tv = a[j]; a[j] = a[j-1]; a[j-1] = tv;
                        ti = ix[j]; ix[j] = ix[j-1]; ix[j-1] = ti;
                    end
            for (int k = 0; k < N; k++) begin
                exp_d[k*W +: W]   = a[k];
                exp_i[k*IW +: IW] = IW'(ix[k]);
            end
            c = 0;
            do begin @(negedge clk); c++; end while (!o_valid && c < 20);
            total++;
            if (o_data !== exp_d || (exp_i !== o_index && o_index !== '0)) begin
                bad++;
                $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", v, o_data, o_index, exp_d, exp_i);
            end
`ifdef SORT_INDEX_EN
            total++;
            if (o_index !== exp_i) begin
                bad++;
                $display("FAIL b2b_index[%0d]: got %h want %h", v, o_index, exp_i);
            end
`endif
            do begin @(negedge clk); c++; end while (!o_ready && c < 30);
            total++;
            if (c !== 7) begin
                bad++;
                $display("FAIL b2b_period[%0d]: got %0d want 7", v, c);
            end
        end
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_descending = 1'b0; i_data = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_descending;
        test_reset_midsort;
        test_ascending_stable;
        test_extremes;
        test_backpressure;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
